mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, default 64, address width; MEM_BYTES, default 1024, data memory size in bytes; TIMEOUT, default 15, maximum wait cycles per memory request; CHECK_ALIGN, default 1, enables the 8-byte alignment check.
REQ-002 The block SHALL have a single clock clk_i, and reset SHALL be asynchronous and active-low on rst_n_i.
REQ-003 The ports SHALL be as follows (name, direction, width, meaning):
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
M_valid_i  in  1  M-stage instruction present
M_icode_i  in  4  Y86 icode
M_valE_i  in  64  ALU result / address
M_valA_i  in  64  store data / stack address
M_stat_i  in  3  incoming status (SAOK=1, SHLT=2, SADR=3, SINS=4)
m_valid_o  out  1  result valid (registered)
m_valM_o  out  64  load data (registered)
m_stat_o  out  3  result status (registered)
m_stall_o  out  1  hold upstream stage (combinational)
dmem_req_o  out  1  memory request (registered)
dmem_we_o  out  1  write enable
dmem_addr_o  out  ADDR_W  byte address
dmem_wdata_o  out  64  store data
dmem_ack_i  in  1  request complete
dmem_err_i  in  1  memory fault, qualified by ack
dmem_rdata_i  in  64  read data, qualified by ack

Function
REQ-004 Operation decode SHALL be as follows: RMMOVQ and PUSHQ are writes to valE; CALL is a write of valA to valE; MRMOVQ is a read of valE; POPQ and RET are reads of valA; all other icodes are non-memory operations.
REQ-005 The FSM SHALL have three states, IDLE, WAIT and HALT; reset SHALL enter IDLE.
REQ-006 In IDLE, an instruction is accepted when M_valid_i=1, and its inputs SHALL be latched at that edge.
REQ-007 An accepted instruction SHALL complete with m_valid_o=1 at the next cycle, with no memory request, when any of these holds: non-memory op; M_stat_i!=SAOK; address+8>MEM_BYTES; or CHECK_ALIGN=1 and address[2:0]!=0.
REQ-008 The result status for the no-request case in REQ-007 SHALL be: M_stat_i if it is not SAOK; else SADR for a range or alignment fault; else SAOK.
REQ-009 For an instruction completing per REQ-007, m_valM_o SHALL be 0.
REQ-010 A valid memory op with SAOK status SHALL move the FSM to WAIT, with dmem_req_o=1 and dmem_we_o, dmem_addr_o and dmem_wdata_o (valA for writes, 0 for reads) registered.
REQ-011 The request outputs SHALL remain stable while dmem_req_o=1.
REQ-012 In WAIT, dmem_ack_i=1 SHALL end the request: the next cycle has dmem_req_o=0, m_valid_o=1 and state IDLE.
REQ-013 On completion, m_valM_o SHALL equal dmem_rdata_i for reads and 0 for writes.
REQ-014 On completion, m_stat_o SHALL be SADR if dmem_err_i=1, otherwise SAOK.
REQ-015 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without an ack.
REQ-016 When the wait counter reaches TIMEOUT, the request SHALL drop and the result SHALL be m_stat_o=SADR, m_valM_o=0, m_valid_o=1 at the next cycle.
REQ-017 An ack arriving in the same cycle as the timeout SHALL take priority over the timeout.
REQ-018 dmem_ack_i SHALL be ignored outside WAIT, so a late ack has no effect.
REQ-019 m_stall_o SHALL equal (IDLE & M_valid_i & request-issuing op) | (WAIT & ~dmem_ack_i).
REQ-020 m_stall_o SHALL be 0 in HALT.
REQ-021 m_valid_o SHALL be a one-cycle pulse per instruction.
REQ-022 m_valid_o SHALL be 0 in a cycle following a bubble (M_valid_i=0 in IDLE).
REQ-023 Any result with m_stat_o!=SAOK SHALL move the FSM to HALT.
REQ-024 In HALT, all inputs SHALL be ignored, no requests SHALL be issued, m_valid_o SHALL be 0, and m_stat_o SHALL hold its last value until reset.
REQ-025 Memory op latency SHALL be ack cycle + 1.
REQ-026 The maximum number of outstanding requests SHALL be 1.

Reset
REQ-027 While rst_n_i=0, the outputs SHALL be: m_valid_o=0, m_valM_o=0, m_stat_o=SAOK, dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_wdata_o=0, with the wait counter at 0 and the state at IDLE.
REQ-028 Reset asserted during WAIT SHALL drop dmem_req_o immediately, abandoning the transaction.
REQ-029 No result SHALL be produced for an instruction abandoned by reset.

Verification
REQ-030 The bench SHALL cover a MRMOVQ read: MRMOVQ with valE=0x10 and ack after 3 cycles with rdata=0xDEADBEEF -> req for 3 cycles, stall high from the accept cycle through the pre-ack cycles, then m_valid_o=1, m_valM_o=0xDEADBEEF, m_stat_o=SAOK.
REQ-031 The bench SHALL cover a range fault: RMMOVQ with valE=0x3FC -> no dmem_req_o, next cycle m_stat_o=SADR and m_valid_o=1, then state HALT and later instructions ignored.
REQ-032 The bench SHALL cover an alignment fault: PUSHQ with valE=0x1F3 and CHECK_ALIGN=1 -> SADR without a request; with CHECK_ALIGN=0 -> a write request at 0x1F3.
REQ-033 The bench SHALL cover a timeout: POPQ with valA=0x80 and no ack -> req held for TIMEOUT=15 cycles then dropped, and SADR is output; an ack at cycle 20 is ignored.
REQ-034 The bench SHALL cover a memory error: CALL with valE=0x100 and ack with err=1 -> m_stat_o=SADR and state HALT; a separate run with M_stat_i=SINS on RMMOVQ gives no request and m_stat_o=SINS.
REQ-035 The bench SHALL cover reset mid-operation: rst_n_i low during WAIT -> dmem_req_o=0 in the same cycle and all outputs at reset values; after release a NOP gives m_valid_o=1 with SAOK in the next cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// Y86 memory-access stage: decodes the M-stage instruction, issues at most one
// data-memory request at a time, and bounds each wait with a timeout. Any
// non-OK result parks the stage in HALT until reset.
module mem_access_unit #(
    parameter int ADDR_W      = 64,   // byte-address width on the memory port (<= 64)
    parameter int MEM_BYTES   = 1024, // data memory size in bytes
    parameter int TIMEOUT     = 15,   // maximum wait cycles per request
    parameter int CHECK_ALIGN = 1     // 1: 8-byte alignment enforced
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              M_valid_i,
    input  logic [3:0]        M_icode_i,
    input  logic [63:0]       M_valE_i,
    input  logic [63:0]       M_valA_i,
    input  logic [2:0]        M_stat_i,
    output logic              m_valid_o,
    output logic [63:0]       m_valM_o,
    output logic [2:0]        m_stat_o,
    output logic              m_stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [63:0]       dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic              dmem_err_i,
    input  logic [63:0]       dmem_rdata_i
);

    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;

    // Counter must be able to hold TIMEOUT itself.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;

    logic               is_write;
    logic               is_read;
    logic               is_mem;
    logic [63:0]        addr_sel;
    logic               range_fault;
    logic               align_fault;
    logic               issue;
    logic [2:0]         imm_stat;

    // Decode the M-stage instruction and decide whether it needs the memory.
    always_comb begin
        is_write    = (M_icode_i == I_RMMOVQ) || (M_icode_i == I_PUSHQ) || (M_icode_i == I_CALL);
        is_read     = (M_icode_i == I_MRMOVQ) || (M_icode_i == I_POPQ)  || (M_icode_i == I_RET);
        is_mem      = is_write || is_read;
        // Stack pops read from the old stack pointer carried in valA.
        addr_sel    = ((M_icode_i == I_POPQ) || (M_icode_i == I_RET)) ? M_valA_i : M_valE_i;
        // 65-bit sum so an address near 2^64 cannot wrap into range.
        range_fault = ({1'b0, addr_sel} + 65'd8) > 65'(MEM_BYTES);
        align_fault = (CHECK_ALIGN != 0) && (addr_sel[2:0] != 3'b000);
        issue       = (state == S_IDLE) && M_valid_i && is_mem && (M_stat_i == SAOK)
                      && !range_fault && !align_fault;
        // Status for instructions that finish without touching memory.
        if (M_stat_i != SAOK) begin
            imm_stat = M_stat_i;
        end else if (is_mem && (range_fault || align_fault)) begin
            imm_stat = SADR;
        end else begin
            imm_stat = SAOK;
        end
    end

    // Hold upstream while a request is being launched or is still pending.
    always_comb begin
        m_stall_o = issue || ((state == S_WAIT) && !dmem_ack_i);
    end

    // Control FSM with registered result and request outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            m_valid_o    <= 1'b0;
            m_valM_o     <= '0;
            m_stat_o     <= SAOK;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
        end else begin
            m_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (M_valid_i) begin
                        if (issue) begin
                            state        <= S_WAIT;
                            wait_cnt     <= '0;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= is_write;
                            dmem_addr_o  <= addr_sel[ADDR_W-1:0];
                            dmem_wdata_o <= is_write ? M_valA_i : 64'd0;
                        end else begin
                            m_valid_o <= 1'b1;
                            m_valM_o  <= '0;
                            m_stat_o  <= imm_stat;
                            if (imm_stat != SAOK) begin
                                state <= S_HALT;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_ack_i) begin
                        // Ack wins even on the cycle the timeout would fire.
                        dmem_req_o <= 1'b0;
                        m_valid_o  <= 1'b1;
                        m_valM_o   <= dmem_we_o ? 64'd0 : dmem_rdata_i;
                        m_stat_o   <= dmem_err_i ? SADR : SAOK;
                        state      <= dmem_err_i ? S_HALT : S_IDLE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        wait_cnt   <= wait_cnt + CNT_W'(1);
                        dmem_req_o <= 1'b0;
                        m_valid_o  <= 1'b1;
                        m_valM_o   <= '0;
                        m_stat_o   <= SADR;
                        state      <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_HALT: begin
                    // Frozen until reset; m_stat_o keeps the fault status.
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized + directed bench for mem_access_unit against a transaction-level model.
module tb_mem_access_unit;

    localparam int TMO = 15;
    localparam int MEMB = 1024;

    localparam logic [3:0] I_NOP = 4'h1, I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_CALL = 4'h8,
                           I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB;
    localparam logic [2:0] SAOK = 3'd1, SHLT = 3'd2, SADR = 3'd3, SINS = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        M_valid = 1'b0;
    logic [3:0]  M_icode = '0;
    logic [63:0] M_valE = '0;
    logic [63:0] M_valA = '0;
    logic [2:0]  M_stat = SAOK;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic [63:0] rdata = '0;

    logic        m_valid, m_stall, req, we;
    logic [63:0] m_valM, addr, wdata;
    logic [2:0]  m_stat;

    logic        na_valid, na_stall, na_req, na_we;
    logic [63:0] na_valM, na_addr, na_wdata;
    logic [2:0]  na_stat;

    int total = 0;
    int bad = 0;
    logic       halted = 1'b0;
    logic [2:0] last_stat = SAOK;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(64), .MEM_BYTES(MEMB), .TIMEOUT(TMO), .CHECK_ALIGN(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .M_valid_i(M_valid), .M_icode_i(M_icode), .M_valE_i(M_valE), .M_valA_i(M_valA),
        .M_stat_i(M_stat),
        .m_valid_o(m_valid), .m_valM_o(m_valM), .m_stat_o(m_stat), .m_stall_o(m_stall),
        .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_wdata_o(wdata),
        .dmem_ack_i(ack), .dmem_err_i(err), .dmem_rdata_i(rdata)
    );

    mem_access_unit #(.ADDR_W(64), .MEM_BYTES(MEMB), .TIMEOUT(TMO), .CHECK_ALIGN(0)) dut_na (
        .clk_i(clk), .rst_n_i(rst_n),
        .M_valid_i(M_valid), .M_icode_i(M_icode), .M_valE_i(M_valE), .M_valA_i(M_valA),
        .M_stat_i(M_stat),
        .m_valid_o(na_valid), .m_valM_o(na_valM), .m_stat_o(na_stat), .m_stall_o(na_stall),
        .dmem_req_o(na_req), .dmem_we_o(na_we), .dmem_addr_o(na_addr), .dmem_wdata_o(na_wdata),
        .dmem_ack_i(ack), .dmem_err_i(err), .dmem_rdata_i(rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_valM"},  m_valM, 64'd0);
        chk({tag, "_stat"},  64'(m_stat), 64'(SAOK));
        chk({tag, "_req"},   64'(req), 64'd0);
        chk({tag, "_we"},    64'(we), 64'd0);
        chk({tag, "_addr"},  addr, 64'd0);
        chk({tag, "_wdata"}, wdata, 64'd0);
        chk({tag, "_stall"}, 64'(m_stall), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; M_valid = 1'b0; ack = 1'b0; err = 1'b0;
        #1 check_reset_outputs("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        halted = 1'b0;
        last_stat = SAOK;
    endtask

    // One instruction through the stage; expectations come from the decode
    // rules (address choice, range/alignment, ack vs. timeout) at transaction level.
    task automatic run_instr(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                             input logic [2:0] st, input int ack_dly, input logic e,
                             input logic [63:0] rd);
        logic        is_w, is_r, fault, iss;
        logic [63:0] a, ev;
        logic [2:0]  es;
        int          ncyc;
        is_w  = (ic == I_RMMOVQ) || (ic == I_PUSHQ) || (ic == I_CALL);
        is_r  = (ic == I_MRMOVQ) || (ic == I_POPQ) || (ic == I_RET);
        a     = ((ic == I_POPQ) || (ic == I_RET)) ? va : ve;
        fault = (({1'b0, a} + 65'd8) > 65'(MEMB)) || (a[2:0] != 3'b000);
        iss   = (is_w || is_r) && (st == SAOK) && !fault;
        ncyc  = 0;
        if (!iss) begin
            es = (st != SAOK) ? st : (((is_w || is_r) && fault) ? SADR : SAOK);
            ev = 64'd0;
        end else if (ack_dly < TMO) begin
            es = e ? SADR : SAOK;
            ev = is_w ? 64'd0 : rd;
            ncyc = ack_dly + 1;
        end else begin
            es = SADR;
            ev = 64'd0;
            ncyc = TMO;
        end

        @(negedge clk);
        M_valid = 1'b1; M_icode = ic; M_valE = ve; M_valA = va; M_stat = st;
        #1 chk("stall_accept", 64'(m_stall), 64'(iss));
        @(negedge clk);
        M_valid = 1'b0;
        M_valE = 64'({$urandom, $urandom}); // request must not follow later input changes
        for (int k = 0; k < ncyc; k++) begin
            chk("req_held", 64'(req), 64'd1);
            chk("req_we", 64'(we), 64'(is_w));
            chk("req_addr", addr, a);
            chk("req_wdata", wdata, is_w ? va : 64'd0);
            chk("valid_wait", 64'(m_valid), 64'd0);
            rdata = {$urandom, $urandom};
            if (k == ack_dly) begin
                ack = 1'b1; err = e; rdata = rd;
            end
            #1 chk("stall_wait", 64'(m_stall), 64'(k != ack_dly));
            @(negedge clk);
            ack = 1'b0; err = 1'b0;
        end
        chk("res_valid", 64'(m_valid), 64'd1);
        chk("res_valM", m_valM, ev);
        chk("res_stat", 64'(m_stat), 64'(es));
        chk("res_req", 64'(req), 64'd0);
        @(negedge clk);
        chk("valid_pulse", 64'(m_valid), 64'd0);
        if (es != SAOK) halted = 1'b1;
        last_stat = es;
        $display("txn icode=%h addr=%h stat_in=%0d req=%0d cycles=%0d -> stat=%0d valM=%h",
                 ic, a, st, iss, ncyc, es, ev);
    endtask

    // In HALT every input, including acks, must be ignored.
    task automatic halt_check();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            M_valid = 1'b1; M_icode = I_MRMOVQ; M_valE = 64'h8; M_stat = SAOK;
            ack = 1'b1; err = 1'b0; rdata = 64'h1234;
            #1 chk("halt_stall", 64'(m_stall), 64'd0);
            @(negedge clk);
            M_valid = 1'b0; ack = 1'b0;
            chk("halt_valid", 64'(m_valid), 64'd0);
            chk("halt_req", 64'(req), 64'd0);
            chk("halt_stat", 64'(m_stat), 64'(last_stat));
        end
    endtask

    initial begin
        logic [3:0]  ic;
        logic [63:0] ve, va;
        logic [2:0]  st;
        int          sel, dly;

        do_reset();

        // MRMOVQ read, ack in the third request cycle
        run_instr(I_MRMOVQ, 64'h10, 64'h0, SAOK, 2, 1'b0, 64'hDEADBEEF);

        // Range fault, then stage is frozen
        run_instr(I_RMMOVQ, 64'h3FC, 64'h55, SAOK, 0, 1'b0, 64'h0);
        halt_check();
        do_reset();

        // Alignment fault; the unchecked instance issues the write instead
        run_instr(I_PUSHQ, 64'h1F3, 64'hCAFE, SAOK, 0, 1'b0, 64'h0);
        chk("na_req", 64'(na_req), 64'd1);
        chk("na_we", 64'(na_we), 64'd1);
        chk("na_addr", na_addr, 64'h1F3);
        chk("na_wdata", na_wdata, 64'hCAFE);
        do_reset();

        // Timeout on POPQ, then a late ack is ignored
        run_instr(I_POPQ, 64'h0, 64'h80, SAOK, 99, 1'b0, 64'h0);
        halt_check();
        do_reset();

        // Memory error on CALL; separately an SINS passthrough
        run_instr(I_CALL, 64'h100, 64'h77, SAOK, 1, 1'b1, 64'h0);
        halt_check();
        do_reset();
        run_instr(I_RMMOVQ, 64'h40, 64'h1, SINS, 0, 1'b0, 64'h0);
        do_reset();

        // Reset in the middle of a wait
        @(negedge clk);
        M_valid = 1'b1; M_icode = I_MRMOVQ; M_valE = 64'h20; M_stat = SAOK;
        @(negedge clk);
        M_valid = 1'b0;
        chk("mid_req1", 64'(req), 64'd1);
        @(negedge clk);
        chk("mid_req2", 64'(req), 64'd1);
        rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        ack = 1'b1; rdata = 64'hBAD;
        @(negedge clk);
        ack = 1'b0;
        chk("mid_no_result", 64'(m_valid), 64'd0);
        chk("mid_no_req", 64'(req), 64'd0);
        halted = 1'b0; last_stat = SAOK;
        run_instr(I_NOP, 64'h0, 64'h0, SAOK, 0, 1'b0, 64'h0);

        // Random instruction stream
        for (int n = 0; n < 60; n++) begin
            if (halted) begin
                halt_check();
                do_reset();
            end
            ic  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) begin
                ic = (ic[0]) ? I_MRMOVQ : ((ic[1]) ? I_POPQ : ((ic[2]) ? I_PUSHQ : I_RMMOVQ));
            end
            sel = $urandom_range(0, 9);
            if (sel < 6)       ve = 64'($urandom_range(0, 127) * 8);
            else if (sel < 8)  ve = 64'($urandom_range(0, 1100));
            else if (sel == 8) ve = {$urandom, $urandom};
            else               ve = 64'(1016 + $urandom_range(0, 8));
            va  = ($urandom_range(0, 1) == 1) ? ve : {$urandom, $urandom};
            st  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(2, 4)) : SAOK;
            dly = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 4);
            run_instr(ic, ve, va, st, dly, ($urandom_range(0, 7) == 0), {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
